// File: rtl/custom_leds_pwm.sv
// Avalon-MM LED driver: per-LED PWM duty, global prescaler, optional blink.
// Ports: clk, reset (sync, active-high), avs_s0_* slave (read latency 1), leds conduit.
// Optional blink block is built when CUSTOM_LEDS_BLINK_EN is defined.
module custom_leds_pwm #(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   avs_s0_address,
    input  logic                avs_s0_read,
    input  logic                avs_s0_write,
    input  logic [31:0]         avs_s0_writedata,
    output logic [31:0]         avs_s0_readdata,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(1);

    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   duty     [NUM_LEDS];
    logic [PWM_BITS-1:0]   duty_act [NUM_LEDS];

    logic                  wr_ctrl;
    logic                  wr_pre;
    logic                  en_d;
    logic                  en_rise;
    logic                  tick;
    logic                  period_end;
    logic [NUM_LEDS-1:0]   pwm_on;
    logic [NUM_LEDS-1:0]   blink_off;
    logic [31:0]           rd_val;
    logic                  unused_wdata;

    // Upper write-data bits are intentionally ignored.
    assign unused_wdata = ^avs_s0_writedata;

    assign wr_ctrl    = avs_s0_write && (avs_s0_address == A_CTRL);
    assign wr_pre     = avs_s0_write && (avs_s0_address == A_PRE);
    // en_d is EN as it will be after this edge; lets a disable
    // blank the LEDs on the same edge the write lands.
    assign en_d       = wr_ctrl ? avs_s0_writedata[0] : en;
    // Latch fresh duties at the enable edge so the first period is clean.
    assign en_rise    = wr_ctrl && avs_s0_writedata[0] && !en;
    assign tick       = en && (pre_cnt == prescale);
    assign period_end = tick && (&pwm_cnt);

`ifdef CUSTOM_LEDS_BLINK_EN
    localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(2 + NUM_LEDS);
    localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(3 + NUM_LEDS);

    logic [NUM_LEDS-1:0] blink_mask;
    logic [15:0]         blink_div;
    logic [15:0]         blink_cnt;
    logic                blink_phase;
    logic                wr_div;

    assign wr_div    = avs_s0_write && (avs_s0_address == A_DIV);
    assign blink_off = blink_phase ? blink_mask : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask  <= '0;
            blink_div   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (avs_s0_write && (avs_s0_address == A_MASK))
                blink_mask <= avs_s0_writedata[NUM_LEDS-1:0];
            if (wr_div)
                blink_div <= avs_s0_writedata[15:0];
            if (!en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (wr_div) begin
                blink_cnt <= '0;
            end else if (period_end) begin
                if (blink_cnt == blink_div) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign blink_off = '0;
`endif

    // Duty all-ones means fully on, not 255/256.
    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            pwm_on[i] = (&duty_act[i]) || (pwm_cnt < duty_act[i]);
    end

    always_comb begin
        rd_val = '0;
        if (avs_s0_address == A_CTRL)
            rd_val[0] = en;
        if (avs_s0_address == A_PRE)
            rd_val[PRESCALE_W-1:0] = prescale;
        for (int i = 0; i < NUM_LEDS; i++)
            if (avs_s0_address == ADDR_W'(2 + i))
                rd_val[PWM_BITS-1:0] = duty[i];
`ifdef CUSTOM_LEDS_BLINK_EN
        if (avs_s0_address == A_MASK)
            rd_val[NUM_LEDS-1:0] = blink_mask;
        if (avs_s0_address == A_DIV)
            rd_val[15:0] = blink_div;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en              <= 1'b0;
            prescale        <= '0;
            pre_cnt         <= '0;
            pwm_cnt         <= '0;
            leds            <= '0;
            avs_s0_readdata <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty[i]     <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (wr_ctrl)
                en <= avs_s0_writedata[0];
            if (wr_pre)
                prescale <= avs_s0_writedata[PRESCALE_W-1:0];

            if (!en || wr_pre || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PRESCALE_W'(1);

            if (!en)
                pwm_cnt <= '0;
            else if (tick)
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);

            for (int i = 0; i < NUM_LEDS; i++) begin
                if (avs_s0_write && (avs_s0_address == ADDR_W'(2 + i)))
                    duty[i] <= avs_s0_writedata[PWM_BITS-1:0];
                if (en_rise || period_end)
                    duty_act[i] <= duty[i];
            end

            leds <= (en && en_d) ? (pwm_on & ~blink_off) : '0;

            if (avs_s0_read)
                avs_s0_readdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_custom_leds_pwm.sv
// Scoreboard bench for custom_leds_pwm: queued expectations for
// read data and LED on-cycle counts, checked by a negedge monitor.
module tb_custom_leds_pwm;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;
    logic [7:0]  leds;

    custom_leds_pwm dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_readdata  (avs_s0_readdata),
        .leds             (leds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_e = 0;
    logic peek = 1'b0;
    logic rd_d = 1'b0;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  m_mask_q[$];
    int          m_len_q[$];
    int          m_exp_q[$];
    string       m_name_q[$];

    logic        busy = 1'b0;
    logic [7:0]  cur_mask;
    int          cur_exp;
    string       cur_name;
    int          m_cnt;
    int          m_rem;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_d <= avs_s0_read | peek;
    end

    // Monitor
    initial begin
        logic [31:0] e;
        string n;
        forever begin
            @(negedge clk);
            if (rd_d) begin
                checks++;
                if (rd_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: readdata=0x%h", avs_s0_readdata);
                end else begin
                    e = rd_exp_q.pop_front();
                    n = rd_name_q.pop_front();
                    if (avs_s0_readdata !== e) begin
                        errors++;
                        $display("FAIL %s: readdata=0x%h expected 0x%h",
                                 n, avs_s0_readdata, e);
                    end
                end
            end
            if (!busy && m_mask_q.size() > 0) begin
                cur_mask = m_mask_q.pop_front();
                m_rem    = m_len_q.pop_front();
                cur_exp  = m_exp_q.pop_front();
                cur_name = m_name_q.pop_front();
                m_cnt    = 0;
                busy     = 1'b1;
            end
            if (busy) begin
                if ((|(leds & cur_mask)) !== 1'b0) m_cnt++;
                m_rem--;
                if (m_rem == 0) begin
                    busy = 1'b0;
                    checks++;
                    if (m_cnt != cur_exp) begin
                        errors++;
                        $display("FAIL %s: on_cycles=%0d expected %0d",
                                 cur_name, m_cnt, cur_exp);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        @(posedge clk); #1;
        avs_s0_write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        @(posedge clk); #1;
        avs_s0_read    = 1'b0;
    endtask

    task automatic rw(input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string n);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_read      = 1'b1;
        avs_s0_write     = 1'b1;
        @(posedge clk); #1;
        avs_s0_read      = 1'b0;
        avs_s0_write     = 1'b0;
    endtask

    task automatic meas(input logic [7:0] m, input int len, input int e, input string n);
        m_mask_q.push_back(m);
        m_len_q.push_back(len);
        m_exp_q.push_back(e);
        m_name_q.push_back(n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000; i++) begin
            if (m_mask_q.size() == 0 && !busy && rd_exp_q.size() == 0) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: pending=%0d expected 0", m_mask_q.size() + rd_exp_q.size());
    endtask

    task automatic wait_ph(input int p);
        for (int i = 0; i < 600; i++) begin
            if (((cyc - cyc_e) & 255) == p) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_ph: phase=%0d expected %0d", (cyc - cyc_e) & 255, p);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time=%0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        avs_s0_address = '0;
        avs_s0_read = 1'b0;
        avs_s0_write = 1'b0;
        avs_s0_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        rd_exp_q.push_back(32'h0);
        rd_name_q.push_back("rst_readdata");
        meas(8'hFF, 5, 0, "rst_leds");
        peek = 1'b1;
        @(posedge clk); #1;
        peek = 1'b0;
        wait_idle();

        // 1: DUTY0=64 -> 64 of 256
        wr(5'd1, 32'd0);
        wr(5'd2, 32'd64);
        wr(5'd0, 32'd1);
        cyc_e = cyc;
        meas(8'h01, 256, 64, "t1_led0");
        meas(8'hFE, 256, 0, "t1_others");
        wait_idle();

        // 2: DUTY1=0 then 255
        wait_ph(100);
        meas(8'h02, 256, 0, "t2_duty0");
        wr(5'd3, 32'd0);
        wait_idle();
        wait_ph(100);
        meas(8'h02, 300, 143, "t2_switch");
        meas(8'h02, 256, 256, "t2_full");
        wr(5'd3, 32'd255);
        wait_idle();

        // 3: DUTY0 64->128 mid-period
        wait_ph(9);
        meas(8'h01, 247, 56, "t3_cur_period");
        meas(8'h01, 256, 128, "t3_next_period");
        wr(5'd2, 32'd128);
        wait_idle();

        // 4: PRESCALE=3
        wr(5'd0, 32'd0);
        wr(5'd1, 32'd3);
        wr(5'd2, 32'd0);
        wr(5'd3, 32'd0);
        wr(5'd4, 32'd2);
        wr(5'd5, 32'd255);
        wr(5'd0, 32'd1);
        meas(8'h04, 1024, 8, "t4_led2");
        meas(8'h08, 1024, 1024, "t4_led3_full");
        meas(8'hF3, 1024, 0, "t4_others");
        wait_idle();
        wr(5'd0, 32'd0);
        meas(8'hFF, 20, 0, "t4_disable");
        rd(5'd0, 32'h0, "t4_ctrl");
        rd(5'd1, 32'h3, "t4_prescale");
        wait_idle();

        // 5: register readback and reset
        wr(5'd5, 32'hA5);
        rd(5'd5, 32'hA5, "t5_duty3");
        rd(5'd31, 32'h0, "t5_unmapped31");
        rw(5'd2, 32'h1FF, 32'h0, "t5_rw_old");
        rd(5'd2, 32'hFF, "t5_rw_new");
        wr(5'd1, 32'd0);
        wr(5'd0, 32'd1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        meas(8'h08, 1, 1, "t5_led3_on");
        wait_idle();
        rd(5'd5, 32'hA5, "t5_pre_reset");
        rd_exp_q.push_back(32'h0);
        rd_name_q.push_back("t5_rst_readdata");
        reset = 1'b1;
        peek = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        peek = 1'b0;
        meas(8'hFF, 300, 0, "t5_rst_leds");
        rd(5'd5, 32'h0, "t5_rst_duty3");
        rd(5'd0, 32'h0, "t5_rst_ctrl");
        wait_idle();

`ifdef CUSTOM_LEDS_BLINK_EN
        // 6: blink
        wr(5'd2, 32'd255);
        wr(5'd10, 32'h1);
        wr(5'd11, 32'h1);
        wr(5'd0, 32'd1);
        @(posedge clk); #1;
        meas(8'h01, 512, 512, "t6_phase0");
        meas(8'h01, 512, 0, "t6_phase1");
        meas(8'h01, 512, 512, "t6_phase0b");
        rd(5'd10, 32'h1, "t6_mask");
        wait_idle();
`else
        wr(5'd10, 32'hFF);
        rd(5'd10, 32'h0, "t6_addr10");
        rd(5'd11, 32'h0, "t6_addr11");
        wait_idle();
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
